rr_index_arbiter: RTL and testbench
===================================

RR_INDEX_ARBITER -- requirements
Module: rr_index_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive grant cycles per owner while other requests are pending; legal range 2..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: synchronous reset, active-high.
REQ-004 Port req, input, 16 bits: request lines; bit i high means requester i wants the shared resource.
REQ-005 Port grant_index, output, 4 bits: binary index of the current owner; feeds the 4-to-16 decoder binary input.
REQ-006 Port grant_valid, output, 1 bit: a grant is active; feeds the decoder enable.
REQ-007 Port grant_start, output, 1 bit: one-cycle pulse in the first cycle of each new grant.

Function
REQ-008 All outputs shall be registered; a request seen at edge N shall produce grant_valid at edge N+1 at the earliest.
REQ-009 The block shall be a two-state FSM: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-010 IDLE to GRANT: any req bit high; the new owner is the first set bit scanning from ptr upward, wrapping 15 to 0.
REQ-011 IDLE with req=0 shall remain IDLE, with grant_index holding its last value.
REQ-012 GRANT while req[grant_index]=1 and no preemption: hold owner; increment hold_cnt, saturating at MAX_HOLD-1.
REQ-013 Release: req[grant_index]=0 in GRANT; if another req is set, a new owner is granted at the next edge with no idle cycle; otherwise go to IDLE.
REQ-014 Preemption: hold_cnt=MAX_HOLD-1 and any other req bit set; the next edge grants the next requester after the owner, even if the owner still requests.
REQ-015 With no other requester, an owner shall keep the grant indefinitely; hold_cnt saturates.
REQ-016 Each new grant (from IDLE, release or preemption) shall set ptr to (new index + 1) mod 16, clear hold_cnt to 0 and pulse grant_start for one cycle.
REQ-017 A new grant to the same index as the previous one (sole requester re-asserting after release through IDLE) shall still pulse grant_start.
REQ-018 Arithmetic on ptr and index is 4-bit modulo 16; hold_cnt is 8 bits.
REQ-019 Starvation bound: a requester held high shall be granted within 15*MAX_HOLD+1 cycles.

Reset
REQ-020 reset=1 at a clock edge shall force IDLE, grant_valid=0, grant_start=0, grant_index=0, ptr=0 and hold_cnt=0; this takes priority over all other activity.
REQ-021 Reset asserted mid-grant shall drop grant_valid at that edge; arbitration resumes from ptr=0 on the first edge after reset deasserts.

Structure
REQ-022 Shared package arb_pkg shall hold NUM_REQ=16, IDX_W=4 and the FSM state enumeration {IDLE, GRANT}.
REQ-023 Combinational sub-module rr_priority_pick (inputs req[15:0], ptr[3:0], mask_idx[3:0], mask_en; outputs idx[3:0], found) shall implement the rotating scan, with mask_en excluding mask_idx for preemption.
REQ-024 rr_index_arbiter shall hold only the FSM, ptr, hold_cnt and output registers.

Verification
REQ-025 Reset, then req=0x0000 for 5 cycles -> grant_valid=0, grant_index=0, grant_start=0 throughout.
REQ-026 req=0x0090 from IDLE, ptr=0 -> next edge grant_index=4, grant_valid=1, grant_start=1; drop bit 4 -> following edge grant_index=7 with no idle cycle.
REQ-027 MAX_HOLD=4, req=0x0003 held -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating; grant_start pulses at each switch.
REQ-028 req=0x8000 then 0x0001 after release, ptr=0 -> grant 15, then wrap to grant 0; ptr becomes 0 then 1.
REQ-029 Sole requester 3 held 20 cycles with MAX_HOLD=8 -> grant_index=3 for all 20 cycles; grant_start high only in the first.
REQ-030 reset pulsed during grant to index 9 with req=0x0200 held -> grant_valid=0 at the reset edge; regrant to 9 one edge after reset deasserts.

Source files
------------

// File: rtl/arb_pkg.sv
//============================================================================
// Module : arb_pkg
// Brief  : Shared sizes and FSM state type for the round-robin index arbiter.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_priority_pick.sv
//============================================================================
// Module : rr_priority_pick
// Brief  : Rotating first-set-bit scan from ptr upward, optional index mask.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [IDX_W-1:0]   mask_idx,
    input  logic               mask_en,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0]   w_req_masked;
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [IDX_W-1:0]     w_offset;

    always_comb begin
        w_req_masked = req;
        if (mask_en) begin
            w_req_masked[mask_idx] = 1'b0;
        end
    end

    // Rotate so that bit 0 of w_req_rot is requester ptr; wrap comes for free.
    assign w_req_dbl = {w_req_masked, w_req_masked};
    assign w_req_rot = w_req_dbl[ptr +: NUM_REQ];

    always_comb begin
        w_offset = '0;
        found    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = IDX_W'(k);
                found    = 1'b1;
            end
        end
    end

    assign idx = ptr + w_offset;

endmodule : rr_priority_pick

`default_nettype wire

// File: rtl/rr_index_arbiter.sv
//============================================================================
// Module : rr_index_arbiter
// Brief  : 16-way round-robin arbiter with hold limit and binary grant index.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_index_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [IDX_W-1:0]   grant_index,
    output logic               grant_valid,
    output logic               grant_start
);

    localparam logic [7:0] c_hold_max = 8'(MAX_HOLD - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_nxt;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_take;

    // While granted, the owner is masked so w_pick_found means "someone else waits".
    rr_priority_pick u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .mask_idx (grant_index),
        .mask_en  (r_state == GRANT),
        .idx      (w_pick_idx),
        .found    (w_pick_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_index]) begin
                    if (w_pick_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_hold_cnt == c_hold_max && w_pick_found) begin
                    w_take = 1'b1;
                end else if (r_hold_cnt != c_hold_max) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_take) begin
            w_hold_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            grant_index <= '0;
            grant_valid <= 1'b0;
            grant_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            grant_valid <= (w_state_nxt == GRANT);
            grant_start <= w_take;
            if (w_take) begin
                grant_index <= w_pick_idx;
                r_ptr       <= w_pick_idx + 4'd1;
            end
        end
    end

endmodule : rr_index_arbiter

`default_nettype wire

// File: tb/tb_rr_index_arbiter.sv
//============================================================================
// Module : tb_rr_index_arbiter
// Brief  : Directed and random checks of rr_index_arbiter against a model.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rr_index_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int BOUND    = 15 * MAX_HOLD + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic [3:0]  grant_index;
    logic        grant_valid;
    logic        grant_start;

    int n_tests = 0;
    int n_fail  = 0;

    int m_valid, m_start, m_idx, m_ptr, m_hold;
    int wait_cnt [16];

    rr_index_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_index (grant_index),
        .grant_valid (grant_valid),
        .grant_start (grant_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester at or after start (mod 16), ignoring index skip.
    function automatic int pick(input logic [15:0] r, input int start, input int skip);
        for (int k = 0; k < 16; k++) begin
            int j;
            j = (start + k) % 16;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [15:0] r);
        int nxt;
        nxt = -1;
        if (rst) begin
            m_valid = 0; m_start = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else begin
            m_start = 0;
            if (m_valid == 0) begin
                nxt = pick(r, m_ptr, -1);
            end else if (!r[m_idx]) begin
                nxt = pick(r, m_ptr, -1);
                if (nxt < 0) m_valid = 0;
            end else if (m_hold == MAX_HOLD - 1) begin
                nxt = pick(r, m_ptr, m_idx);
            end else begin
                m_hold = m_hold + 1;
            end
            if (nxt >= 0) begin
                m_valid = 1; m_idx = nxt; m_ptr = (nxt + 1) % 16; m_hold = 0; m_start = 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [15:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        model_step(rst, r);
        #1;
        check_eq("valid", 32'(grant_valid), 32'(m_valid));
        check_eq("start", 32'(grant_start), 32'(m_start));
        check_eq("index", 32'(grant_index), 32'(m_idx));
        for (int i = 0; i < 16; i++) begin
            if (rst) begin
                wait_cnt[i] = 0;
            end else if (grant_valid && int'(grant_index) == i) begin
                if (wait_cnt[i] > 0) check_eq("starve", 32'(wait_cnt[i] <= BOUND), 32'd1);
                wait_cnt[i] = 0;
            end else if (r[i]) begin
                wait_cnt[i] = wait_cnt[i] + 1;
            end else begin
                wait_cnt[i] = 0;
            end
        end
    endtask

    task automatic expect_out(input string tag, input int v, input int s, input int idx);
        check_eq({tag, "_valid"}, 32'(grant_valid), 32'(v));
        check_eq({tag, "_start"}, 32'(grant_start), 32'(s));
        check_eq({tag, "_index"}, 32'(grant_index), 32'(idx));
    endtask

    initial begin
        logic [15:0] cur;
        logic        rst;
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;

        step(1'b1, 16'h0000);
        step(1'b1, 16'h0000);
        expect_out("reset", 0, 0, 0);

        for (int c = 0; c < 5; c++) begin
            step(1'b0, 16'h0000);
            expect_out("idle", 0, 0, 0);
        end

        step(1'b0, 16'h0090);
        expect_out("first4", 1, 1, 4);
        step(1'b0, 16'h0080);
        expect_out("rel7", 1, 1, 7);

        step(1'b1, 16'h0000);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 16'h0003);
            expect_out("alt", 1, int'(c % 4 == 0), (c / 4) % 2);
        end

        step(1'b1, 16'h0000);
        step(1'b0, 16'h8000);
        expect_out("g15", 1, 1, 15);
        step(1'b0, 16'h0000);
        expect_out("idle15", 0, 0, 15);
        step(1'b0, 16'h0001);
        expect_out("wrap0", 1, 1, 0);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0003);
        expect_out("ptr1", 1, 1, 1);

        step(1'b1, 16'h0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 16'h0008);
            expect_out("sole3", 1, int'(c == 0), 3);
        end
        step(1'b0, 16'h0000);
        expect_out("rel3", 0, 0, 3);
        step(1'b0, 16'h0008);
        expect_out("regrant3", 1, 1, 3);

        step(1'b1, 16'h0000);
        step(1'b0, 16'h0200);
        expect_out("g9", 1, 1, 9);
        step(1'b0, 16'h0200);
        step(1'b1, 16'h0200);
        expect_out("rst9", 0, 0, 0);
        step(1'b0, 16'h0200);
        expect_out("after9", 1, 1, 9);

        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: cur = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    1: cur = 16'h0001 << $urandom_range(15);
                    2: cur = 16'($urandom);
                    default: cur = cur ^ (16'h0001 << $urandom_range(15));
                endcase
            end
            rst = ($urandom_range(199) == 0);
            step(rst, cur);
        end

        for (int i = 0; i < 16; i++) begin
            check_eq("starve_end", 32'(wait_cnt[i] <= BOUND), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_index_arbiter

`default_nettype wire
